m2s_fifo_write_arbiter: RTL and testbench
=========================================

M2S_FIFO_WRITE_ARBITER -- requirements
Module: m2s_fifo_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, FIFO write-data width.
REQ-002 SHALL have parameter MAX_BURST, default 4, max words accepted per grant under contention; legal range 1..255.
REQ-003 SHALL have port wrclock  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_write / req1_write  input  1  requester write strobes (Avalon-MM write).
REQ-006 SHALL have ports req0_writedata / req1_writedata  input  DATA_W  requester write data.
REQ-007 SHALL have ports req0_waitrequest / req1_waitrequest  output  1  per-requester stall.
REQ-008 SHALL have port fifo_write  output  1  write strobe to FIFO write slave.
REQ-009 SHALL have port fifo_writedata  output  DATA_W  data to FIFO write slave.
REQ-010 SHALL have port fifo_waitrequest  input  1  FIFO write-slave stall (high when full or in reset).
REQ-011 SHALL have port grant  output  2  one-hot current owner; 2'b00 when idle.

Function
REQ-012 SHALL implement FSM states IDLE, GNT0, GNT1; grant = {state==GNT1, state==GNT0}.
REQ-013 In IDLE: fifo_write=0, both reqN_waitrequest=1.
REQ-014 In GNTn: fifo_write=reqn_write, fifo_writedata=reqn_writedata, reqn_waitrequest=fifo_waitrequest, other requester waitrequest=1; all combinational from registered state.
REQ-015 In IDLE, fifo_writedata SHALL be 0.
REQ-016 Word accepted in GNTn when reqn_write=1 and fifo_waitrequest=0; burst counter increments per accepted word only.
REQ-017 Arbitration latency: request seen in IDLE -> grant asserted next cycle; first word can be accepted that cycle.
REQ-018 Simultaneous requests in IDLE: grant goes to requester not served last (round-robin pointer last_served).
REQ-019 GNTn release on accepted word with burst count = MAX_BURST-1: go to GNT(other) if other requesting, else remain GNTn with counter cleared.
REQ-020 GNTn release when reqn_write=0: go to GNT(other) if other requesting, else IDLE.
REQ-021 Stalled cycles (reqn_write=1, fifo_waitrequest=1) SHALL NOT advance the counter nor release the grant; no starvation beyond MAX_BURST accepted words.
REQ-022 On every grant change, burst counter clears and last_served updates to the releasing owner.
REQ-023 Data SHALL never be written to the FIFO for a non-granted requester; no word lost or duplicated across a handover.

Reset
REQ-024 While reset_n=0: state=IDLE, counter=0, last_served=1 (req0 wins first tie), grant=00, fifo_write=0, fifo_writedata=0, both reqN_waitrequest=1.
REQ-025 Reset assertion mid-burst SHALL abort immediately, asynchronously; in-flight word is not written.
REQ-026 First arbitration SHALL occur on first rising edge after reset_n deasserts.

Configuration
REQ-027 Macro M2S_ARB_STATS_EN: when defined, adds outputs words0, words1 (32 bits each), counting accepted words per requester, wrapping 0xFFFFFFFF->0, reset to 0.
REQ-028 Without M2S_ARB_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-029 Package m2s_arb_pkg SHALL hold FSM state typedef (IDLE/GNT0/GNT1), default DATA_W, MAX_BURST limits, burst-counter width constant.
REQ-030 Round-robin next-owner selection SHALL be sub-module m2s_arb_rr_pick (inputs: req pair, last_served; output: one-hot pick).

Verification
REQ-031 Reset then req0 writes 3 words 0x0001..0x0003, fifo_waitrequest=0 -> grant=01 one cycle after request, 3 fifo_write pulses in order, then IDLE.
REQ-032 Both request from IDLE continuously, MAX_BURST=4 -> grant 01 for 4 words, 10 for 4 words, alternate; FIFO sequence A0..A3,B0..B3,A4...
REQ-033 req0 granted, fifo_waitrequest=1 for 5 cycles mid-burst -> req0_waitrequest=1, counter frozen, no release, no extra fifo_write.
REQ-034 req1 alone, MAX_BURST=4, 10 words -> grant stays 10 throughout, all 10 words accepted without gap.
REQ-035 reset_n low during 2nd word of burst -> same cycle grant=00, both waitrequest=1, fifo_write=0; after release req0 wins tie.
REQ-036 With M2S_ARB_STATS_EN, scenario REQ-032 for 12 accepted words -> words0=8... per accepted split, words0+words1=12; preset wrap test 0xFFFFFFFF -> 0.

Source files
------------

// File: rtl/m2s_arb_pkg.sv
// Shared types and limits for the two-master FIFO write arbiter.
// Also used by the optional per-requester word counters (macro M2S_ARB_STATS_EN).
package m2s_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int DATA_W_DEF    = 16;
  localparam int MAX_BURST_DEF = 4;
  localparam int MAX_BURST_MIN = 1;
  localparam int MAX_BURST_MAX = 255;

  // Wide enough for MAX_BURST_MAX-1, the largest count the burst counter holds.
  localparam int BCNT_W = 8;

endpackage

// File: rtl/m2s_arb_rr_pick.sv
// Round-robin owner choice for two requesters: a lone request wins outright,
// and a tie goes to whichever requester was not served last.
module m2s_arb_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_served_i,
  output logic [1:0] pick_o
);

  always_comb begin
    pick_o = req_i;
    if (&req_i) pick_o = last_served_i ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/m2s_fifo_write_arbiter.sv
// Arbitrates two Avalon-MM write masters onto one FIFO write slave, with a
// bounded burst per grant. Define M2S_ARB_STATS_EN to add accepted-word counters.
module m2s_fifo_write_arbiter
  import m2s_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              wrclock,
  input  logic              reset_n,
  input  logic              req0_write,
  input  logic [DATA_W-1:0] req0_writedata,
  input  logic              req1_write,
  input  logic [DATA_W-1:0] req1_writedata,
  input  logic              fifo_waitrequest,
  output logic              req0_waitrequest,
  output logic              req1_waitrequest,
  output logic              fifo_write,
  output logic [DATA_W-1:0] fifo_writedata,
`ifdef M2S_ARB_STATS_EN
  output logic [31:0]       words0,
  output logic [31:0]       words1,
`endif
  output logic [1:0]        grant
);

  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST - 1);

  arb_state_e        state_q, state_d;
  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic              last_q, last_d;   // 0: req0 served last, 1: req1
  logic [1:0]        pick;
  logic              owner, own_write, oth_write;

  m2s_arb_rr_pick u_rr_pick (
    .req_i         ({req1_write, req0_write}),
    .last_served_i (last_q),
    .pick_o        (pick)
  );

  assign owner     = (state_q == GNT1);
  assign own_write = owner ? req1_write : req0_write;
  assign oth_write = owner ? req0_write : req1_write;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick[0])      state_d = GNT0;
        else if (pick[1]) state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (!own_write) begin
          cnt_d   = '0;
          last_d  = owner;
          state_d = oth_write ? (owner ? GNT0 : GNT1) : IDLE;
        end else if (!fifo_waitrequest) begin
          if (cnt_q == BURST_LAST) begin
            // Burst exhausted: hand over only if the other side is waiting.
            cnt_d = '0;
            if (oth_write) begin
              last_d  = owner;
              state_d = owner ? GNT0 : GNT1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign grant = {state_q == GNT1, state_q == GNT0};

  always_comb begin
    fifo_write       = 1'b0;
    fifo_writedata   = '0;
    req0_waitrequest = 1'b1;
    req1_waitrequest = 1'b1;
    unique case (state_q)
      GNT0: begin
        fifo_write       = req0_write;
        fifo_writedata   = req0_writedata;
        req0_waitrequest = fifo_waitrequest;
      end
      GNT1: begin
        fifo_write       = req1_write;
        fifo_writedata   = req1_writedata;
        req1_waitrequest = fifo_waitrequest;
      end
      default: ;
    endcase
  end

`ifdef M2S_ARB_STATS_EN
  logic [31:0] words0_q, words1_q;

  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      words0_q <= '0;
      words1_q <= '0;
    end else begin
      if (state_q == GNT0 && req0_write && !fifo_waitrequest) words0_q <= words0_q + 32'd1;
      if (state_q == GNT1 && req1_write && !fifo_waitrequest) words1_q <= words1_q + 32'd1;
    end
  end

  assign words0 = words0_q;
  assign words1 = words1_q;
`endif

endmodule

// File: tb/tb_m2s_fifo_write_arbiter.sv
// Directed bench for m2s_fifo_write_arbiter (MAX_BURST=4, DATA_W=16): a vector
// table for single-owner and stall behaviour, plus multi-cycle handover/reset sequences.
module tb_m2s_fifo_write_arbiter;

  logic        wrclock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_write = 1'b0, req1_write = 1'b0;
  logic [15:0] req0_writedata = '0, req1_writedata = '0;
  logic        fifo_waitrequest = 1'b0;
  logic        req0_waitrequest, req1_waitrequest;
  logic        fifo_write;
  logic [15:0] fifo_writedata;
  logic [1:0]  grant;
`ifdef M2S_ARB_STATS_EN
  logic [31:0] words0, words1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  m2s_fifo_write_arbiter #(.DATA_W(16), .MAX_BURST(4)) dut (
    .wrclock          (wrclock),
    .reset_n          (reset_n),
    .req0_write       (req0_write),
    .req0_writedata   (req0_writedata),
    .req1_write       (req1_write),
    .req1_writedata   (req1_writedata),
    .fifo_waitrequest (fifo_waitrequest),
    .req0_waitrequest (req0_waitrequest),
    .req1_waitrequest (req1_waitrequest),
    .fifo_write       (fifo_write),
    .fifo_writedata   (fifo_writedata),
`ifdef M2S_ARB_STATS_EN
    .words0           (words0),
    .words1           (words1),
`endif
    .grant            (grant)
  );

  always #5 wrclock = ~wrclock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        rst_n;
    logic        w0;
    logic [15:0] d0;
    logic        w1;
    logic [15:0] d1;
    logic        fw;
    logic [1:0]  e_gnt;
    logic        e_fwr;
    logic [15:0] e_fd;
    logic        e_wr0;
    logic        e_wr1;
  } vec_t;

  vec_t vecs[21];

  task automatic do_reset();
    @(negedge wrclock);
    reset_n = 1'b0; req0_write = 1'b0; req1_write = 1'b0;
    req0_writedata = '0; req1_writedata = '0; fifo_waitrequest = 1'b0;
    @(negedge wrclock);
    reset_n = 1'b1;
  endtask

  function automatic logic [15:0] rr_expect(input int k);
    int grp = k / 4;
    int idx = (grp / 2) * 4 + (k % 4);
    return (grp % 2 == 0) ? 16'(32'hA000 + idx) : 16'(32'hB000 + idx);
  endfunction

  initial begin
    int ia, ib, nacc, first_cyc, last_cyc;

    //           rst w0  d0        w1  d1        fw   gnt    fwr fd        wr0 wr1
    vecs[0]  = '{0, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 0, 16'h0000, 1, 1};
    vecs[1]  = '{1, 1, 16'h0001, 0, 16'h0000, 0, 2'b00, 0, 16'h0000, 1, 1};
    vecs[2]  = '{1, 1, 16'h0001, 0, 16'h0000, 0, 2'b01, 1, 16'h0001, 0, 1};
    vecs[3]  = '{1, 1, 16'h0002, 0, 16'h0000, 0, 2'b01, 1, 16'h0002, 0, 1};
    vecs[4]  = '{1, 1, 16'h0003, 0, 16'h0000, 0, 2'b01, 1, 16'h0003, 0, 1};
    vecs[5]  = '{1, 0, 16'h0000, 0, 16'h0000, 0, 2'b01, 0, 16'h0000, 0, 1};
    vecs[6]  = '{1, 1, 16'h0010, 0, 16'h0000, 0, 2'b00, 0, 16'h0000, 1, 1};
    vecs[7]  = '{1, 1, 16'h0010, 0, 16'h0000, 0, 2'b01, 1, 16'h0010, 0, 1};
    vecs[8]  = '{1, 1, 16'h0011, 1, 16'h00B0, 1, 2'b01, 1, 16'h0011, 1, 1};
    vecs[9]  = '{1, 1, 16'h0011, 1, 16'h00B0, 1, 2'b01, 1, 16'h0011, 1, 1};
    vecs[10] = '{1, 1, 16'h0011, 1, 16'h00B0, 1, 2'b01, 1, 16'h0011, 1, 1};
    vecs[11] = '{1, 1, 16'h0011, 1, 16'h00B0, 1, 2'b01, 1, 16'h0011, 1, 1};
    vecs[12] = '{1, 1, 16'h0011, 1, 16'h00B0, 1, 2'b01, 1, 16'h0011, 1, 1};
    vecs[13] = '{1, 1, 16'h0011, 1, 16'h00B0, 0, 2'b01, 1, 16'h0011, 0, 1};
    vecs[14] = '{1, 1, 16'h0012, 1, 16'h00B0, 0, 2'b01, 1, 16'h0012, 0, 1};
    vecs[15] = '{1, 1, 16'h0013, 1, 16'h00B0, 0, 2'b01, 1, 16'h0013, 0, 1};
    vecs[16] = '{1, 1, 16'h0014, 1, 16'h00B0, 0, 2'b10, 1, 16'h00B0, 1, 0};
    vecs[17] = '{1, 1, 16'h0014, 0, 16'h0000, 0, 2'b10, 0, 16'h0000, 1, 0};
    vecs[18] = '{1, 1, 16'h0014, 0, 16'h0000, 0, 2'b01, 1, 16'h0014, 0, 1};
    vecs[19] = '{1, 0, 16'h0000, 0, 16'h0000, 0, 2'b01, 0, 16'h0000, 0, 1};
    vecs[20] = '{1, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 0, 16'h0000, 1, 1};

    // Table: reset state, 3-word burst, stall mid-burst, burst-limit handover.
    for (int i = 0; i < 21; i++) begin
      @(negedge wrclock);
      reset_n          = vecs[i].rst_n;
      req0_write       = vecs[i].w0;
      req0_writedata   = vecs[i].d0;
      req1_write       = vecs[i].w1;
      req1_writedata   = vecs[i].d1;
      fifo_waitrequest = vecs[i].fw;
      #1;
      check($sformatf("v%0d_grant", i), {30'd0, grant}, {30'd0, vecs[i].e_gnt});
      check($sformatf("v%0d_fifo_write", i), {31'd0, fifo_write}, {31'd0, vecs[i].e_fwr});
      check($sformatf("v%0d_fifo_writedata", i), {16'd0, fifo_writedata}, {16'd0, vecs[i].e_fd});
      check($sformatf("v%0d_req0_waitrequest", i), {31'd0, req0_waitrequest}, {31'd0, vecs[i].e_wr0});
      check($sformatf("v%0d_req1_waitrequest", i), {31'd0, req1_waitrequest}, {31'd0, vecs[i].e_wr1});
    end

    // Both masters stream continuously: bursts of 4 alternate A/B.
    do_reset();
    ia = 0; ib = 0; nacc = 0; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 40 && nacc < 12; cyc++) begin
      @(negedge wrclock);
      req0_write = 1'b1; req0_writedata = 16'(32'hA000 + ia);
      req1_write = 1'b1; req1_writedata = 16'(32'hB000 + ib);
      fifo_waitrequest = 1'b0;
      #1;
      check($sformatf("rr_c%0d_onehot", cyc), {31'd0, req0_waitrequest | req1_waitrequest}, 32'd1);
      if (fifo_write && !fifo_waitrequest) begin
        check($sformatf("rr_w%0d_data", nacc), {16'd0, fifo_writedata}, {16'd0, rr_expect(nacc)});
        check($sformatf("rr_w%0d_grant", nacc), {30'd0, grant},
              ((nacc / 4) % 2 == 0) ? 32'd1 : 32'd2);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        nacc++;
      end
      if (req0_write && !req0_waitrequest) ia++;
      if (req1_write && !req1_waitrequest) ib++;
    end
    check("rr_words_accepted", 32'(nacc), 32'd12);
    check("rr_no_gaps", 32'(last_cyc - first_cyc), 32'd11);
`ifdef M2S_ARB_STATS_EN
    check("stats_words0", words0, 32'd8);
    check("stats_words1", words1, 32'd4);
    check("stats_sum", words0 + words1, 32'd12);
`endif

    // req1 alone for 10 words: grant never drops, no bubbles.
    do_reset();
    ib = 0; nacc = 0; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge wrclock);
      req0_write = 1'b0;
      req1_write = (ib < 10);
      req1_writedata = 16'(32'hC000 + ib);
      fifo_waitrequest = 1'b0;
      #1;
      if (fifo_write && !fifo_waitrequest) begin
        check($sformatf("solo_w%0d_data", nacc), {16'd0, fifo_writedata}, 32'hC000 + 32'(nacc));
        check($sformatf("solo_w%0d_grant", nacc), {30'd0, grant}, 32'd2);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        nacc++;
      end
      if (req1_write && !req1_waitrequest) ib++;
    end
    check("solo_words_accepted", 32'(nacc), 32'd10);
    check("solo_no_gaps", 32'(last_cyc - first_cyc), 32'd9);

    // Asynchronous reset during the second word of a burst.
    do_reset();
    @(negedge wrclock);
    req0_write = 1'b1; req0_writedata = 16'h0D01;
    @(negedge wrclock);
    #1;
    check("ares_first_word", {16'd0, fifo_writedata}, 32'h0D01);
    @(negedge wrclock);
    req0_writedata = 16'h0D02;
    #1;
    check("ares_second_in_flight", {31'd0, fifo_write}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("ares_grant", {30'd0, grant}, 32'd0);
    check("ares_fifo_write", {31'd0, fifo_write}, 32'd0);
    check("ares_fifo_writedata", {16'd0, fifo_writedata}, 32'd0);
    check("ares_req0_waitrequest", {31'd0, req0_waitrequest}, 32'd1);
    check("ares_req1_waitrequest", {31'd0, req1_waitrequest}, 32'd1);
    @(negedge wrclock);
    reset_n = 1'b1; req0_write = 1'b1; req1_write = 1'b1;
    req0_writedata = 16'h0E00; req1_writedata = 16'h0F00;
    #1;
    check("ares_idle_after_release", {30'd0, grant}, 32'd0);
    @(negedge wrclock);
    #1;
    check("ares_req0_wins_tie", {30'd0, grant}, 32'd1);
    check("ares_tie_data", {16'd0, fifo_writedata}, 32'h0E00);

`ifdef M2S_ARB_STATS_EN
    // Counter wrap: preset words0 to all-ones, then accept one req0 word.
    do_reset();
    @(negedge wrclock);
    dut.words0_q = 32'hFFFF_FFFF;
    req0_write = 1'b1; req0_writedata = 16'h1234;
    @(negedge wrclock);
    #1;
    check("wrap_pre", words0, 32'hFFFF_FFFF);
    @(negedge wrclock);
    req0_write = 1'b0;
    #1;
    check("wrap_post", words0, 32'd0);
`endif

    @(negedge wrclock);
    req0_write = 1'b0; req1_write = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
